// File: rtl/display_scan_if.sv
// Signal bundle between the display scanner and whoever feeds it values.
// The master side supplies the value, load strobe and enables; the slave
// side (the scanner) returns the anode selects, digit code and frame pulse.
interface display_scan_if;
    logic [31:0] value_in;
    logic        load;
    logic        blank_lz;
    logic [7:0]  digit_en;
    logic [7:0]  an;
    logic [3:0]  digit_data;
    logic [2:0]  digit_idx;
    logic        frame_done;

    modport master (
        output value_in, load, blank_lz, digit_en,
        input  an, digit_data, digit_idx, frame_done
    );

    modport slave (
        input  value_in, load, blank_lz, digit_en,
        output an, digit_data, digit_idx, frame_done
    );
endinterface

// File: rtl/display_scan.sv
// Eight-digit seven-segment scanner. A loaded value waits in a shadow
// register and is committed only when the scan wraps from digit 7 to digit 0,
// so a single frame never mixes old and new digits. Each digit slot starts
// with BLANK_CYC all-dark cycles to keep the previous digit from ghosting.
module display_scan #(
    parameter int DIGITS      = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 16
) (
    input logic           clk,
    input logic           rst,
    display_scan_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int DW = $clog2(DIGITS);
    localparam logic [CW-1:0] C_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] C_BLANK = CW'(BLANK_CYC);
    localparam logic [DW-1:0] D_LAST  = DW'(DIGITS - 1);

    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic [31:0]   shadow;
    logic          pending;
    logic [31:0]   disp;
    logic          wrap_q;

    logic          slot_end;
    logic          frame_end;
    logic [7:0]    zero_from;
    logic          lz_blank;
    logic          visible;
    logic [3:0]    cur_nib;

    // Slot/frame boundary decode from the scan position.
    always_comb begin
        slot_end  = (c == C_LAST);
        frame_end = slot_end && (d == D_LAST);
    end

    // zero_from[i] is set when nibbles 7..i of the displayed value are all zero.
    always_comb begin
        zero_from    = '0;
        zero_from[7] = (disp[31:28] == 4'h0);
        for (int i = 6; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] && (disp[4*i +: 4] == 4'h0);
        end
    end

    // Visibility of the current slot; digit 0 is exempt from LZ blanking so 0 shows as "0".
    always_comb begin
        cur_nib  = disp[{d, 2'b00} +: 4];
        lz_blank = bus.blank_lz && (d != '0) && zero_from[d];
        visible  = bus.digit_en[d] && !lz_blank && (c >= C_BLANK);
    end

    // Scan position: slot counter and digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            c <= '0;
            d <= '0;
        end else if (slot_end) begin
            c <= '0;
            d <= frame_end ? '0 : d + 1'b1;
        end else begin
            c <= c + 1'b1;
        end
    end

    // Value capture and frame-aligned commit; a load in the wrap cycle bypasses the shadow.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow  <= '0;
            pending <= 1'b0;
            disp    <= '0;
        end else if (frame_end) begin
            if (bus.load) begin
                disp   <= bus.value_in;
                shadow <= bus.value_in;
            end else if (pending) begin
                disp <= shadow;
            end
            pending <= 1'b0;
        end else if (bus.load) begin
            shadow  <= bus.value_in;
            pending <= 1'b1;
        end
    end

    // Registered outputs; frame_done trails the wrap by one so it lines up with digit 0's first output.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_q         <= 1'b0;
            bus.an         <= 8'hFF;
            bus.digit_data <= 4'hF;
            bus.digit_idx  <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            wrap_q         <= frame_end;
            bus.frame_done <= wrap_q;
            bus.digit_idx  <= 3'(d);
            if (visible) begin
                bus.an         <= ~(8'b1 << d);
                bus.digit_data <= cur_nib;
            end else begin
                bus.an         <= 8'hFF;
                bus.digit_data <= 4'hF;
            end
        end
    end
endmodule

// File: doc/display_scan.md
# display_scan

Time-multiplexing scanner for the board's 8-digit common-anode seven-segment display. Latches a 32-bit value (eight 4-bit digits), cycles through the digits at a fixed refresh rate, and drives the active-low anode selects plus the 4-bit digit code consumed by the downstream `seven_segment_display` decoder. Updates are committed only at frame boundaries, with optional leading-zero blanking and an inter-digit ghosting guard.

## Interface
- `DIGITS`, 8, number of digits scanned; fixed at 8 in this design, and port widths assume 8.
- `REFRESH_DIV`, 100000, clock cycles per digit slot; must be ≥ 2.
- `BLANK_CYC`, 16, cycles at the start of each slot with all anodes off; must be < `REFRESH_DIV`.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `value_in`  in  32  digit `d` = `value_in[4d+3:4d]`; digit 7 is the most significant.
- `load`  in  1  single-cycle strobe; captures `value_in`.
- `blank_lz`  in  1  enables leading-zero blanking.
- `digit_en`  in  8  per-digit enable; 0 forces that digit dark.
- `an`  out  8  anode selects, active-low, one-hot-low or all-high.
- `digit_data`  out  4  code for the decoder; 4'hF means blank.
- `digit_idx`  out  3  index of the current slot.
- `frame_done`  out  1  one-cycle pulse at each frame wrap.

## Operation
- Internal state:
  - slot counter `c` (0..`REFRESH_DIV`-1);
  - digit index `d` (0..7);
  - `shadow` (32 b);
  - `pending` (1 b);
  - `disp` (32 b).
- `load`: `shadow <= value_in`, `pending <= 1`. A repeated load before commit overwrites `shadow`; the last one wins.
- Counter: `c` increments every cycle.
  - At `c == REFRESH_DIV-1`: `c <= 0` and `d <= d+1`.
  - `d` wraps 7 → 0.
- Commit: on the 7 → 0 wrap, if `pending` then `disp <= shadow` and `pending <= 0`.
  - If `load` is asserted in the wrap cycle itself, `disp <= value_in` (bypass) and `pending <= 0`.
  - The display never shows a mix of old and new values within one frame.
- Leading-zero blank: digit `d` (d ≥ 1) is blanked when `blank_lz` = 1 and nibbles 7..d of `disp` are all zero. Digit 0 is never LZ-blanked, so a value of 0 shows a single "0".
- Digit is visible when `digit_en[d]`, not LZ-blanked, and `c >= BLANK_CYC`.
- Outputs (registered):
  - Visible digit: `an` = ~(1<<d) and `digit_data` = `disp` nibble `d`.
  - Otherwise: `an` = 8'hFF and `digit_data` = 4'hF.
  - `digit_idx` = `d` in all cases.
- Nibbles A–E pass through unchanged (the decoder renders them blank). 4'hF is the blank code.
- `blank_lz` and `digit_en` are sampled live each cycle and are not frame-aligned.

## Timing
- Reset values:
  - `c` = 0, `d` = 0, `shadow` = 0, `pending` = 0, `disp` = 0;
  - `an` = 8'hFF, `digit_data` = 4'hF, `digit_idx` = 0, `frame_done` = 0.
- Output latency: 1 cycle. Outputs at edge n+1 reflect `c`/`d`/`disp` as they stood after edge n.
- Slot length is exactly `REFRESH_DIV` cycles; frame length is 8·`REFRESH_DIV`.
- `frame_done` is high for exactly 1 cycle, aligned with the first output cycle of digit 0. The first pulse after reset occurs at cycle 8·`REFRESH_DIV`+1.
- A load takes effect in `an`/`digit_data` at the next frame start. Worst case ≈ 8·`REFRESH_DIV`+1 cycles.
- `rst` mid-frame: all state returns to reset values on that edge, a pending load is discarded, and scanning restarts at digit 0, c = 0.

## Test plan
All scenarios use `REFRESH_DIV`=4, `BLANK_CYC`=1.
- Reset → `an`=8'hFF, `digit_data`=4'hF, `frame_done`=0. First frame shows digit 0 = 0 with `an`=8'hFE on slot cycles 1–3; digits 1–7 are dark with `blank_lz`=1.
- `load` 32'h12345678, `blank_lz`=0, `digit_en`=8'hFF:
  - next frame, digit 0 shows 8 with `an`=8'hFE, through digit 7 showing 1 with `an`=8'h7F;
  - each slot has 1 all-dark cycle followed by 3 lit cycles;
  - `frame_done` pulses every 32 cycles.
- `load` 32'h00000305, `blank_lz`=1 → digits 0–2 show 5, 0, 3. Digits 3–7 have `an` bit high and `digit_data`=4'hF.
- Mid-frame `load` 32'h11111111 during digit 3 of a 32'h22222222 frame → digits 3–7 of that frame still show 2. Value 1 appears from the next digit 0 onward.
- `load` coincident with the frame wrap cycle → the new value shows immediately at digit 0 and `pending`=0. Back-to-back loads A then B mid-frame → only B is displayed.
- `digit_en`=8'b1010_1010 → even digits are dark. Asserting `rst` during digit 5 → outputs go to reset values the next cycle, `disp`=0, and a pending value is never shown.
